// File: rtl/spi_txrx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_txrx_fifo_if                                                |
// | Brief    : CPU-side and master-side signal bundle for spi_txrx_fifo.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface spi_txrx_fifo_if #(
    parameter int DEPTH = 8
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          tx_wr;
    logic [7:0]    tx_wdata;
    logic          tx_full;
    logic          tx_empty;
    logic [LW-1:0] tx_level;
    logic          rx_rd;
    logic [7:0]    rx_rdata;
    logic          rx_empty;
    logic          rx_full;
    logic [LW-1:0] rx_level;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          clr_err;
    logic          flush;
    logic          m_busy;
    logic          m_tx_valid;
    logic [7:0]    m_tx_data;
    logic          m_rx_valid;
    logic [7:0]    m_rx_data;

    modport slave (
        input  tx_wr, tx_wdata, rx_rd, clr_err, flush, m_busy, m_rx_valid, m_rx_data,
        output tx_full, tx_empty, tx_level, rx_rdata, rx_empty, rx_full, rx_level,
               tx_ovf, rx_ovf, m_tx_valid, m_tx_data
    );

    modport master (
        output tx_wr, tx_wdata, rx_rd, clr_err, flush, m_busy, m_rx_valid, m_rx_data,
        input  tx_full, tx_empty, tx_level, rx_rdata, rx_empty, rx_full, rx_level,
               tx_ovf, rx_ovf, m_tx_valid, m_tx_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_txrx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_txrx_fifo                                                   |
// | Brief    : TX/RX byte FIFOs with a one-transfer-at-a-time launch FSM.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spi_txrx_fifo #(
    parameter int DEPTH    = 8,
    parameter bit RX_BLOCK = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    spi_txrx_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] C_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0] C_LVL_ONE = LW'(1);
    localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [LW-1:0] r_tx_lvl, r_rx_lvl;
    logic          r_tx_ovf, r_rx_ovf;
    logic [7:0]    r_m_tx_data;
    state_t        r_state, w_state_nxt;
    logic          w_launch;

    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic          w_tx_push, w_rx_push, w_rx_pop, w_rx_drop;
    logic [PW-1:0] w_rx_waddr;

    assign w_tx_full  = (r_tx_lvl == C_FULL);
    assign w_tx_empty = (r_tx_lvl == '0);
    assign w_rx_full  = (r_rx_lvl == C_FULL);
    assign w_rx_empty = (r_rx_lvl == '0);

    assign w_tx_push  = bus.tx_wr && !w_tx_full && !bus.flush;
    assign w_rx_pop   = bus.rx_rd && !w_rx_empty && !bus.flush;
    // A received byte is never lost to a flush: it lands in slot 0 of the emptied FIFO.
    assign w_rx_push  = bus.m_rx_valid && (bus.flush || !w_rx_full || w_rx_pop);
    assign w_rx_drop  = bus.m_rx_valid && w_rx_full && !w_rx_pop && !bus.flush;
    assign w_rx_waddr = bus.flush ? '0 : r_rx_wp;

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty && !bus.m_busy && !(RX_BLOCK && w_rx_full)) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (bus.m_rx_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_m_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_m_tx_data <= r_tx_mem[r_tx_rp];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_lvl <= '0;
        end else if (bus.flush) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_lvl <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_launch)  r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_launch})
                2'b10:   r_tx_lvl <= r_tx_lvl + 1'b1;
                2'b01:   r_tx_lvl <= r_tx_lvl - 1'b1;
                default: r_tx_lvl <= r_tx_lvl;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_lvl <= '0;
        end else if (bus.flush) begin
            r_rx_rp  <= '0;
            r_rx_wp  <= w_rx_push ? C_PTR_ONE : '0;
            r_rx_lvl <= w_rx_push ? C_LVL_ONE : '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_lvl <= r_rx_lvl + 1'b1;
                2'b01:   r_rx_lvl <= r_rx_lvl - 1'b1;
                default: r_rx_lvl <= r_rx_lvl;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp]  <= bus.tx_wdata;
        if (w_rx_push) r_rx_mem[w_rx_waddr] <= bus.m_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else if (bus.clr_err) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (bus.tx_wr && w_tx_full) r_tx_ovf <= 1'b1;
            if (w_rx_drop)              r_rx_ovf <= 1'b1;
        end
    end

    assign bus.tx_full    = w_tx_full;
    assign bus.tx_empty   = w_tx_empty;
    assign bus.tx_level   = r_tx_lvl;
    assign bus.rx_full    = w_rx_full;
    assign bus.rx_empty   = w_rx_empty;
    assign bus.rx_level   = r_rx_lvl;
    assign bus.rx_rdata   = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
    assign bus.tx_ovf     = r_tx_ovf;
    assign bus.rx_ovf     = r_rx_ovf;
    assign bus.m_tx_valid = (r_state == S_LAUNCH);
    assign bus.m_tx_data  = r_m_tx_data;
endmodule
`default_nettype wire

// File: tb/tb_spi_txrx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_txrx_fifo                                                |
// | Brief    : Directed bench: RX_BLOCK=1 instance A, RX_BLOCK=0 instance B.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_spi_txrx_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_txrx_fifo_if #(.DEPTH(DEPTH)) ifa ();
    spi_txrx_fifo_if #(.DEPTH(DEPTH)) ifb ();

    spi_txrx_fifo #(.DEPTH(DEPTH), .RX_BLOCK(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    spi_txrx_fifo #(.DEPTH(DEPTH), .RX_BLOCK(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;
    int launch_cnt = 0;

    always @(negedge clk) if (ifa.m_tx_valid) launch_cnt = launch_cnt + 1;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       rxv;
        logic [7:0] rxd;
        logic       clr;
        logic       fl;
        logic [3:0] etx;
        logic [3:0] erx;
        logic [7:0] erd;
        logic       etov;
        logic       erov;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int wr, input int wd, input int rd, input int rxv,
                                input int rxd, input int clr, input int fl, input int etx,
                                input int erx, input int erd, input int etov, input int erov);
        vec_t v;
        v.wr = wr[0];   v.wd = wd[7:0];   v.rd = rd[0];    v.rxv = rxv[0];
        v.rxd = rxd[7:0]; v.clr = clr[0]; v.fl = fl[0];    v.etx = etx[3:0];
        v.erx = erx[3:0]; v.erd = erd[7:0]; v.etov = etov[0]; v.erov = erov[0];
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(input int maxc, output logic ok, output logic [7:0] d);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < maxc && !ok; i++) begin
            tick();
            if (ifa.m_tx_valid) begin
                ok = 1'b1;
                d  = ifa.m_tx_data;
            end
        end
    endtask

    // Model master: release busy, catch one launch, stay busy 16 cycles, return ~data.
    task automatic xfer(input logic [7:0] exp_d, input string nm);
        logic       ok;
        logic [7:0] d;
        ifa.m_busy = 1'b0;
        wait_launch(20, ok, d);
        check({nm, "_launch_seen"}, ok, 1);
        check({nm, "_launch_data"}, d, exp_d);
        ifa.m_busy = 1'b1;
        repeat (16) tick();
        ifa.m_busy      = 1'b0;
        ifa.m_rx_valid  = 1'b1;
        ifa.m_rx_data   = ~d;
        tick();
        ifa.m_rx_valid  = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] d);
        ifa.tx_wr    = 1'b1;
        ifa.tx_wdata = d;
        tick();
        ifa.tx_wr    = 1'b0;
    endtask

    task automatic idle_inputs();
        ifa.tx_wr = 0; ifa.tx_wdata = 0; ifa.rx_rd = 0; ifa.clr_err = 0; ifa.flush = 0;
        ifa.m_busy = 0; ifa.m_rx_valid = 0; ifa.m_rx_data = 0;
        ifb.tx_wr = 0; ifb.tx_wdata = 0; ifb.rx_rd = 0; ifb.clr_err = 0; ifb.flush = 0;
        ifb.m_busy = 1; ifb.m_rx_valid = 0; ifb.m_rx_data = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [7:0] d;
        int         lc0;

        // B: expected state after each edge
        vq.push_back(mk(1,'h11,0,0,'h00,0,0, 1,0,'h00,0,0));
        vq.push_back(mk(1,'h22,0,0,'h00,0,0, 2,0,'h00,0,0));
        vq.push_back(mk(0,'h00,0,1,'h10,0,0, 2,1,'h10,0,0));
        vq.push_back(mk(0,'h00,0,1,'h20,0,0, 2,2,'h10,0,0));
        vq.push_back(mk(0,'h00,1,0,'h00,0,0, 2,1,'h20,0,0));
        vq.push_back(mk(0,'h00,1,1,'h30,0,0, 2,1,'h30,0,0));
        vq.push_back(mk(0,'h00,1,0,'h00,0,0, 2,0,'h00,0,0));
        vq.push_back(mk(0,'h00,1,0,'h00,0,0, 2,0,'h00,0,0));
        for (int k = 0; k < 8; k++)
            vq.push_back(mk(0,'h00,0,1,'h40+k,0,0, 2,k+1,'h40,0,0));
        vq.push_back(mk(0,'h00,0,1,'h99,0,0, 2,8,'h40,0,1));
        vq.push_back(mk(0,'h00,0,0,'h00,1,0, 2,8,'h40,0,0));
        vq.push_back(mk(0,'h00,1,1,'h9A,0,0, 2,8,'h41,0,0));
        vq.push_back(mk(0,'h00,0,1,'h9B,1,0, 2,8,'h41,0,0));
        vq.push_back(mk(1,'h33,1,0,'h00,0,1, 0,0,'h00,0,0));
        vq.push_back(mk(0,'h00,0,1,'h5C,0,0, 0,1,'h5C,0,0));

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_tx_empty",  ifa.tx_empty, 1);
        check("rst_tx_full",   ifa.tx_full, 0);
        check("rst_tx_level",  ifa.tx_level, 0);
        check("rst_rx_empty",  ifa.rx_empty, 1);
        check("rst_rx_full",   ifa.rx_full, 0);
        check("rst_rx_level",  ifa.rx_level, 0);
        check("rst_ovf",       {ifa.tx_ovf, ifa.rx_ovf}, 0);
        check("rst_m_tx_valid", ifa.m_tx_valid, 0);
        check("rst_m_tx_data", ifa.m_tx_data, 0);
        check("rst_rx_rdata",  ifa.rx_rdata, 0);

        foreach (vq[i]) begin
            ifb.tx_wr = vq[i].wr;  ifb.tx_wdata = vq[i].wd; ifb.rx_rd = vq[i].rd;
            ifb.m_rx_valid = vq[i].rxv; ifb.m_rx_data = vq[i].rxd;
            ifb.clr_err = vq[i].clr; ifb.flush = vq[i].fl;
            tick();
            ifb.tx_wr = 0; ifb.rx_rd = 0; ifb.m_rx_valid = 0; ifb.clr_err = 0; ifb.flush = 0;
            check($sformatf("vec%0d_tx_level", i), ifb.tx_level, vq[i].etx);
            check($sformatf("vec%0d_rx_level", i), ifb.rx_level, vq[i].erx);
            check($sformatf("vec%0d_rx_rdata", i), ifb.rx_rdata, vq[i].erd);
            check($sformatf("vec%0d_tx_ovf", i),   ifb.tx_ovf,   vq[i].etov);
            check($sformatf("vec%0d_rx_ovf", i),   ifb.rx_ovf,   vq[i].erov);
        end

        // single byte: launch two edges after the write
        push_a(8'hA5);
        check("a1_tx_empty_E0", ifa.tx_empty, 0);
        check("a1_valid_E0",    ifa.m_tx_valid, 0);
        tick();
        check("a1_valid_E1",    ifa.m_tx_valid, 1);
        check("a1_data_E1",     ifa.m_tx_data, 8'hA5);
        check("a1_tx_empty_E1", ifa.tx_empty, 1);
        tick();
        check("a1_valid_E2",    ifa.m_tx_valid, 0);
        ifa.m_rx_valid = 1'b1; ifa.m_rx_data = 8'h5A;
        tick();
        ifa.m_rx_valid = 1'b0;
        check("a1_rx_empty",    ifa.rx_empty, 0);
        check("a1_rx_rdata",    ifa.rx_rdata, 8'h5A);
        ifa.rx_rd = 1'b1; tick(); ifa.rx_rd = 1'b0;
        check("a1_rx_drained",  ifa.rx_empty, 1);

        // three bytes through the model master
        ifa.m_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_a(8'(i + 1));
        lc0 = launch_cnt;
        for (int i = 0; i < 3; i++) xfer(8'(i + 1), $sformatf("a2_x%0d", i));
        repeat (5) tick();
        check("a2_launch_count", launch_cnt - lc0, 3);
        check("a2_rx_level", ifa.rx_level, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("a2_rx_byte%0d", i), ifa.rx_rdata, 8'hFE - 8'(i));
            ifa.rx_rd = 1'b1; tick(); ifa.rx_rd = 1'b0;
        end
        check("a2_rx_empty", ifa.rx_empty, 1);

        // TX overflow with the master stalled
        ifa.m_busy = 1'b1;
        for (int i = 0; i <= DEPTH; i++) push_a(8'h80 + 8'(i));
        check("a3_tx_full",  ifa.tx_full, 1);
        check("a3_tx_level", ifa.tx_level, DEPTH);
        check("a3_tx_ovf",   ifa.tx_ovf, 1);
        ifa.clr_err = 1'b1; tick(); ifa.clr_err = 1'b0;
        check("a3_tx_ovf_clr", ifa.tx_ovf, 0);
        lc0 = launch_cnt;
        for (int i = 0; i < DEPTH; i++) xfer(8'h80 + 8'(i), $sformatf("a3_x%0d", i));
        repeat (5) tick();
        check("a3_launch_count", launch_cnt - lc0, DEPTH);
        check("a3_tx_empty",     ifa.tx_empty, 1);
        check("a3_rx_full",      ifa.rx_full, 1);

        // RX full blocks the launch until one byte is read
        lc0 = launch_cnt;
        ifa.m_busy = 1'b0;
        push_a(8'h55);
        repeat (10) tick();
        check("a4_blocked_no_launch", launch_cnt - lc0, 0);
        check("a4_tx_level",          ifa.tx_level, 1);
        ifa.rx_rd = 1'b1; tick(); ifa.rx_rd = 1'b0;
        xfer(8'h55, "a4_unblock");
        check("a4_rx_level", ifa.rx_level, DEPTH);
        check("a4_rx_ovf",   ifa.rx_ovf, 0);
        check("a4_rx_head",  ifa.rx_rdata, 8'h7E);

        // flush while a transfer is in flight
        ifa.flush = 1'b1; tick(); ifa.flush = 1'b0;
        check("a5_pre_rx_level", ifa.rx_level, 0);
        for (int i = 0; i < 4; i++) push_a(8'hC1 + 8'(i));
        check("a5_tx_queued", ifa.tx_level, 3);
        check("a5_inflight",  ifa.m_tx_data, 8'hC1);
        ifa.flush = 1'b1; tick(); ifa.flush = 1'b0;
        check("a5_flush_tx_level", ifa.tx_level, 0);
        check("a5_flush_rx_level", ifa.rx_level, 0);
        ifa.m_rx_valid = 1'b1; ifa.m_rx_data = 8'h3E; tick(); ifa.m_rx_valid = 1'b0;
        check("a5_late_rx_level", ifa.rx_level, 1);
        check("a5_late_rx_rdata", ifa.rx_rdata, 8'h3E);

        // reset during ACTIVE
        push_a(8'h77);
        wait_launch(5, ok, d);
        check("a6_launch_seen", ok, 1);
        push_a(8'h78);
        rst = 1'b1; tick(); rst = 1'b0;
        check("a6_tx_empty",  ifa.tx_empty, 1);
        check("a6_tx_level",  ifa.tx_level, 0);
        check("a6_rx_level",  ifa.rx_level, 0);
        check("a6_rx_rdata",  ifa.rx_rdata, 0);
        check("a6_valid",     ifa.m_tx_valid, 0);
        check("a6_m_tx_data", ifa.m_tx_data, 0);
        check("a6_ovf",       {ifa.tx_ovf, ifa.rx_ovf}, 0);
        ifa.m_rx_valid = 1'b1; ifa.m_rx_data = 8'h12; tick(); ifa.m_rx_valid = 1'b0;
        check("a6_late_rx_level", ifa.rx_level, 1);
        check("a6_late_rx_rdata", ifa.rx_rdata, 8'h12);
        push_a(8'h34);
        check("a6_idle_valid_E0", ifa.m_tx_valid, 0);
        tick();
        check("a6_idle_valid_E1", ifa.m_tx_valid, 1);
        check("a6_idle_data_E1",  ifa.m_tx_data, 8'h34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
